// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. Two WIDTH-bit operands arrive over a valid/ready
// handshake, are added LSB-first one bit per clock by a single full adder
// (two half_adder instances plus an OR), and the WIDTH-bit sum together with
// the final carry is returned over a second valid/ready handshake.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a/b valid
//   in_ready   out  1      controller can accept operands (IDLE only)
//   a, b       in   WIDTH  operands
//   out_valid  out  1      sum/carry_out valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a+b modulo 2^WIDTH, held until the next result
//   carry_out  out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
//
// Timing
//   Operands accepted at edge T0 -> out_valid high after edge T0+WIDTH.
//   After the result handshake the block spends one cycle in IDLE before it
//   can accept again, so a new pair is never taken on the result edge.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// half_adder
//   Combinational half adder: s = x ^ y, c = x & y.
//   Ports: x, y (in, 1 bit); s, c (out, 1 bit).
// -----------------------------------------------------------------------------
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    // Bit counter needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;

    // Registered copies of every output port.
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             busy_r;

    // Full-adder slice signals.
    logic             ha0_s_s;
    logic             ha0_c_s;
    logic             bit_sum_s;
    logic             ha1_c_s;
    logic             carry_nxt_s;

    // Sum shift register next value; built from a WIDTH+1 concatenation so
    // that WIDTH=1 needs no special casing of the [WIDTH-1:1] slice.
    logic [WIDTH:0]   sum_cat_s;
    logic [WIDTH-1:0] sum_sh_nxt_s;

    // First half adder: operand bits.
    half_adder u_ha0 (
        .x (a_sh_r[0]),
        .y (b_sh_r[0]),
        .s (ha0_s_s),
        .c (ha0_c_s)
    );

    // Second half adder: partial sum plus the held carry.
    half_adder u_ha1 (
        .x (ha0_s_s),
        .y (carry_r),
        .s (bit_sum_s),
        .c (ha1_c_s)
    );

    // The two half-adder carries can never both be 1, so OR completes the full adder.
    assign carry_nxt_s  = ha0_c_s | ha1_c_s;
    assign sum_cat_s    = {bit_sum_s, sum_sh_r};
    assign sum_sh_nxt_s = WIDTH'(sum_cat_s >> 1'b1);

    // FSM, operand/sum shift registers, carry flop and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            sum_sh_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            count_r     <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_sh_r     <= a;
                        b_sh_r     <= b;
                        carry_r    <= 1'b0;
                        count_r    <= CNT_ZERO;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    a_sh_r   <= a_sh_r >> 1'b1;
                    b_sh_r   <= b_sh_r >> 1'b1;
                    carry_r  <= carry_nxt_s;
                    sum_sh_r <= sum_sh_nxt_s;
                    count_r  <= count_r + CNT_ONE;
                    if (count_r == LAST_CNT) begin
                        // Last bit: publish the completed result together with out_valid.
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        sum_r       <= sum_sh_nxt_s;
                        carry_out_r <= carry_nxt_s;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    state_r     <= ST_IDLE;
                    count_r     <= CNT_ZERO;
                    carry_r     <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Drives a WIDTH=8 and a WIDTH=1 instance of serial_adder_ctrl. A transaction
// level model (phase + remaining-bit countdown + integer a+b) predicts every
// output on every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [2];
    logic        ordy [2];
    logic [31:0] av   [2];
    logic [31:0] bv   [2];

    logic        ir8, ov8, co8, bz8;
    logic [7:0]  s8;
    logic        ir1, ov1, co1, bz1;
    logic [0:0]  s1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (ir8),
        .a         (av[0][7:0]),
        .b         (bv[0][7:0]),
        .out_valid (ov8),
        .out_ready (ordy[0]),
        .sum       (s8),
        .carry_out (co8),
        .busy      (bz8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (ir1),
        .a         (av[1][0:0]),
        .b         (bv[1][0:0]),
        .out_valid (ov1),
        .out_ready (ordy[1]),
        .sum       (s1),
        .carry_out (co1),
        .busy      (bz1)
    );

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 computing, 2 result pending
    int          ph      [2];
    int          left    [2];
    logic [63:0] op      [2];
    logic [31:0] exp_sum [2];
    logic        exp_c   [2];

    function automatic int wof(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            int          wk;
            logic [63:0] mask;
            wk   = wof(k);
            mask = (64'd1 << wk) - 64'd1;
            if (!rst_n) begin
                ph[k]      = 0;
                left[k]    = 0;
                exp_sum[k] = 32'd0;
                exp_c[k]   = 1'b0;
            end else if (ph[k] == 0) begin
                if (iv[k]) begin
                    op[k]   = ({32'd0, av[k]} & mask) + ({32'd0, bv[k]} & mask);
                    left[k] = wk;
                    ph[k]   = 1;
                end
            end else if (ph[k] == 1) begin
                left[k] = left[k] - 1;
                if (left[k] == 0) begin
                    ph[k]      = 2;
                    exp_sum[k] = 32'(op[k] & mask);
                    exp_c[k]   = op[k][wk];
                end
            end else begin
                if (ordy[k]) ph[k] = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready8",  32'(ir8), 32'(ph[0] == 0));
            check("out_valid8", 32'(ov8), 32'(ph[0] == 2));
            check("busy8",      32'(bz8), 32'(ph[0] != 0));
            check("sum8",       32'(s8),  exp_sum[0]);
            check("carry8",     32'(co8), 32'(exp_c[0]));
            check("in_ready1",  32'(ir1), 32'(ph[1] == 0));
            check("out_valid1", 32'(ov1), 32'(ph[1] == 2));
            check("busy1",      32'(bz1), 32'(ph[1] != 0));
            check("sum1",       32'(s1),  exp_sum[1]);
            check("carry1",     32'(co1), 32'(exp_c[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one operand pair to the 8-bit DUT and wait (bounded) for its result.
    task automatic send8(input logic [7:0] x, input logic [7:0] y,
                         input logic [8:0] want, input string nm);
        int n;
        av[0] = {24'd0, x};
        bv[0] = {24'd0, y};
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin
            step();
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'd8);
        check({nm, "_sum"},     32'(s8), {23'd0, want[7:0]});
        check({nm, "_carry"},   32'(co8), {31'd0, want[8]});
        check({nm, "_model"},   {23'd0, exp_c[0], exp_sum[0][7:0]}, {23'd0, want});
    endtask

    task automatic release8();
        ordy[0] = 1'b1;
        step();
        ordy[0] = 1'b0;
        check("release_in_ready8", 32'(ir8), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; av[k] = 32'd0; bv[k] = 32'd0;
            ph[k] = 0; left[k] = 0; op[k] = 64'd0; exp_sum[k] = 32'd0; exp_c[k] = 1'b0;
        end

        // Reset state
        step(); step(); step();
        chk_en = 1'b1;
        check("rst_in_ready",  32'(ir8), 32'd1);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_sum",       32'(s8),  32'd0);
        check("rst_carry",     32'(co8), 32'd0);
        check("rst_busy",      32'(bz8), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic sums
        send8(8'h5A, 8'h3C, 9'h096, "t1");
        release8();
        send8(8'hFF, 8'h01, 9'h100, "t2a");
        release8();
        send8(8'hFF, 8'hFF, 9'h1FE, "t2b");

        // Backpressure: result must hold while out_ready stays low
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_sum",       32'(s8),  32'h0FE);
            check("bp_carry",     32'(co8), 32'd1);
            check("bp_in_ready",  32'(ir8), 32'd0);
        end
        release8();
        check("bp_sum_retained", 32'(s8), 32'h0FE);

        // Operands changing during RUN with in_valid held high
        av[0] = 32'h33; bv[0] = 32'h44; iv[0] = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            av[0] = $urandom; bv[0] = $urandom;
            step();
        end
        check("hold_out_valid", 32'(ov8), 32'd1);
        check("hold_sum",       32'(s8),  32'h77);
        check("hold_carry",     32'(co8), 32'd0);
        ordy[0] = 1'b1;
        step();
        step();
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        for (int i = 0; i < 20 && !ov8; i++) step();
        check("hold_second_done", 32'(ov8), 32'd1);
        release8();

        // Reset in the middle of RUN (count=3)
        av[0] = 32'h11; bv[0] = 32'h22; iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready_async", 32'(ir8), 32'd1);
        step();
        rst_n = 1'b1;
        check("abort_in_ready",  32'(ir8), 32'd1);
        check("abort_out_valid", 32'(ov8), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("abort_no_result", 32'(ov8), 32'd0);
        end
        send8(8'h01, 8'h02, 9'h003, "t5");
        release8();

        // WIDTH=1 instance, back-to-back transfers
        av[1] = 32'd1; bv[1] = 32'd1; iv[1] = 1'b1; ordy[1] = 1'b1;
        step();
        check("w1_not_yet_valid", 32'(ov1), 32'd0);
        step();
        check("w1_out_valid", 32'(ov1), 32'd1);
        check("w1_sum",       32'(s1),  32'd0);
        check("w1_carry",     32'(co1), 32'd1);
        for (int i = 0; i < 12; i++) step();
        iv[1] = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic on both instances with occasional reset pulses
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 2) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                av[k]   = $urandom;
                bv[k]   = $urandom;
            end
            rst_n = ($urandom_range(0, 150) != 0);
            step();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
